// File: rtl/cve2_rvfi_trace_buffer.sv
// -----------------------------------------------------------------------------
// cve2_rvfi_trace_buffer
//
// Flight recorder for cve2 retirement traces. It sits on the RVFI retirement
// port and stores one record per retired instruction in a circular buffer of
// Depth entries. Records drain oldest-first on a valid/ready stream, and
// capture and drain can run in the same cycle.
//
// When the buffer is full, cfg_wrap_i selects what happens to a new record:
//   0 - the new record is discarded (stop-when-full)
//   1 - the oldest record is overwritten
// Every record lost this way is counted in dropped_o.
//
// An optional trap trigger freezes capture after PostTrigger further records.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rvfi_*_i              retirement port of the core
//   cfg_enable_i          capture enable
//   cfg_wrap_i            0: stop when full, 1: overwrite oldest
//   cfg_trig_en_i         arm the trap trigger
//   clear_i               flush the buffer and counters; also leaves FROZEN
//   rec_valid_o/ready_i   drain handshake; a pop is valid & ready
//   rec_data_o            {[rd_wdata], rd_addr, intr, trap, insn, pc}, pc in LSBs
//   level_o               number of records held
//   dropped_o             number of records lost (saturating)
//   frozen_o              high once the trigger window has closed
// -----------------------------------------------------------------------------
module cve2_rvfi_trace_buffer #(
  parameter int unsigned Depth        = 16,
  parameter int unsigned PostTrigger  = 4,
  parameter int unsigned CaptureWdata = 1,
  parameter int unsigned DropCntW     = 16,
  localparam int unsigned RecW        = 71 + 32 * CaptureWdata,
  localparam int unsigned PtrW        = $clog2(Depth),
  localparam int unsigned LvlW        = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rvfi_valid_i,
  input  logic [31:0]         rvfi_pc_rdata_i,
  input  logic [31:0]         rvfi_insn_i,
  input  logic                rvfi_trap_i,
  input  logic                rvfi_intr_i,
  input  logic [4:0]          rvfi_rd_addr_i,
  input  logic [31:0]         rvfi_rd_wdata_i,
  input  logic                cfg_enable_i,
  input  logic                cfg_wrap_i,
  input  logic                cfg_trig_en_i,
  input  logic                clear_i,
  output logic                rec_valid_o,
  input  logic                rec_ready_i,
  output logic [RecW-1:0]     rec_data_o,
  output logic [LvlW-1:0]     level_o,
  output logic [DropCntW-1:0] dropped_o,
  output logic                frozen_o
);

  // PostTrigger is at most Depth-1, so a pointer-sized counter always holds it.
  localparam int unsigned CntW = PtrW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [DropCntW-1:0]   dropped_q, dropped_d;
  logic [CntW-1:0]       post_cnt_q, post_cnt_d;

  logic [RecW-1:0]       mem_q [Depth];
  logic [RecW-1:0]       rec_in;
  logic [70:0]           rec_base;

  logic push, pop, full, write_en, lose, overwrite, trigger;

  // ---------------------------------------------------------------------------
  // Record packing
  // ---------------------------------------------------------------------------
  assign rec_base = {rvfi_rd_addr_i, rvfi_intr_i, rvfi_trap_i, rvfi_insn_i, rvfi_pc_rdata_i};

  if (CaptureWdata != 0) begin : g_wdata
    assign rec_in = {rvfi_rd_wdata_i, rec_base};
  end else begin : g_no_wdata
    logic unused_wdata;
    assign unused_wdata = ^rvfi_rd_wdata_i;
    assign rec_in       = rec_base;
  end

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    push     = rvfi_valid_i && ((state_q == CAPTURE) || (state_q == POST));
    pop      = (level_q != '0) && rec_ready_i;
    full     = (level_q == LvlW'(Depth));
    // With a full buffer a record is still written if a slot frees up this
    // cycle (pop) or if the oldest record may be sacrificed (wrap).
    write_en  = push && (!full || pop || cfg_wrap_i);
    lose      = push && full && !pop;
    overwrite = lose && cfg_wrap_i;
    trigger   = push && rvfi_trap_i && cfg_trig_en_i;

    wr_ptr_d = write_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = (pop || overwrite) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // An overwrite replaces a record, so it leaves the level unchanged.
    level_d = level_q;
    if ((write_en && !overwrite) && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!(write_en && !overwrite) && pop) begin
      level_d = level_q - 1'b1;
    end

    dropped_d = dropped_q;
    if (lose && (dropped_q != '1)) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        // Dropping capture wins over a trigger in the same cycle; the record
        // itself is still stored.
        if (!cfg_enable_i) begin
          state_d = IDLE;
        end else if (trigger) begin
          if (PostTrigger == 0) begin
            state_d = FROZEN;
          end else begin
            state_d    = POST;
            post_cnt_d = CntW'(PostTrigger);
          end
        end
      end
      POST: begin
        if (!cfg_enable_i) begin
          state_d    = IDLE;
          post_cnt_d = '0;
        end else if (push) begin
          // Every push counts, including one lost to a full buffer.
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == CntW'(1)) state_d = FROZEN;
        end
      end
      FROZEN: begin
        state_d = FROZEN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; clear_i has the same effect as reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dropped_q  <= '0;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dropped_q  <= dropped_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  // Record storage has no reset; validity is tracked by the level.
  always_ff @(posedge clk_i) begin
    if (write_en && !rst_i && !clear_i) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: first-word fall-through from the read pointer.
  // ---------------------------------------------------------------------------
  assign rec_data_o  = mem_q[rd_ptr_q];
  assign rec_valid_o = (level_q != '0);
  assign level_o     = level_q;
  assign dropped_o   = dropped_q;
  assign frozen_o    = (state_q == FROZEN);

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
module tb_cve2_rvfi_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rvfi_valid_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic        rvfi_trap_i;
  logic        rvfi_intr_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic        cfg_enable_i;
  logic        cfg_wrap_i;
  logic        cfg_trig_en_i;
  logic        clear_i;
  logic        rec_ready_i;

  logic         rec_valid_o;
  logic [102:0] rec_data_o;
  logic [4:0]   level_o;
  logic [15:0]  dropped_o;
  logic         frozen_o;

  logic         s_rec_valid_o;
  logic [70:0]  s_rec_data_o;
  logic [4:0]   s_level_o;
  logic [1:0]   s_dropped_o;
  logic         s_frozen_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  cve2_rvfi_trace_buffer #(
    .Depth(16), .PostTrigger(4), .CaptureWdata(1), .DropCntW(16)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .cfg_enable_i(cfg_enable_i), .cfg_wrap_i(cfg_wrap_i), .cfg_trig_en_i(cfg_trig_en_i),
    .clear_i(clear_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_data_o(rec_data_o), .level_o(level_o), .dropped_o(dropped_o), .frozen_o(frozen_o)
  );

  // Second instance: narrow drop counter and no write-data field.
  cve2_rvfi_trace_buffer #(
    .Depth(16), .PostTrigger(4), .CaptureWdata(0), .DropCntW(2)
  ) u_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
    .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .cfg_enable_i(cfg_enable_i), .cfg_wrap_i(cfg_wrap_i), .cfg_trig_en_i(cfg_trig_en_i),
    .clear_i(clear_i), .rec_valid_o(s_rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_data_o(s_rec_data_o), .level_o(s_level_o), .dropped_o(s_dropped_o), .frozen_o(s_frozen_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one retirement for one clock edge.
  task automatic push(input logic [31:0] pc, input logic trap);
    rvfi_valid_i    = 1'b1;
    rvfi_pc_rdata_i = pc;
    rvfi_insn_i     = pc ^ 32'h1234_5678;
    rvfi_trap_i     = trap;
    rvfi_rd_wdata_i = pc + 32'd1;
    step();
    rvfi_valid_i    = 1'b0;
    rvfi_trap_i     = 1'b0;
  endtask

  // Flush, then spend one cycle in IDLE so capture is running again.
  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rec_valid_o); end
    n_cmp++; if (dropped_o !== 16'd0) begin n_bad++; $display("FAIL reset_dropped: got %0d expected 0", dropped_o); end
    n_cmp++; if (frozen_o !== 1'b0) begin n_bad++; $display("FAIL reset_frozen: got %b expected 0", frozen_o); end
    // IDLE with capture disabled ignores retirements.
    push(32'h0000_0040, 1'b0);
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL idle_ignore: level got %0d expected 0", level_o); end
    $display("test_reset: level=%0d valid=%b dropped=%0d frozen=%b", level_o, rec_valid_o, dropped_o, frozen_o);
  endtask

  task automatic test_fifo_order();
    logic [102:0] exp_rec;
    logic [31:0]  exp_pc;
    cfg_enable_i = 1'b1;
    step();
    push(32'h100, 1'b0);
    push(32'h104, 1'b0);
    push(32'h108, 1'b0);
    exp_rec = {32'h101, 5'd7, 1'b0, 1'b0, 32'h1234_5778, 32'h100};
    n_cmp++; if (level_o !== 5'd3) begin n_bad++; $display("FAIL fifo_level: got %0d expected 3", level_o); end
    n_cmp++; if (rec_data_o !== exp_rec) begin n_bad++; $display("FAIL fifo_record: got %h expected %h", rec_data_o, exp_rec); end
    n_cmp++; if (s_rec_data_o !== exp_rec[70:0]) begin n_bad++; $display("FAIL fifo_record_nowdata: got %h expected %h", s_rec_data_o, exp_rec[70:0]); end
    step();  // stalled consumer: head must hold
    n_cmp++; if (rec_data_o[31:0] !== 32'h100) begin n_bad++; $display("FAIL fifo_hold: got %h expected 100", rec_data_o[31:0]); end
    rec_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      n_cmp++; if (rec_data_o[31:0] !== exp_pc) begin n_bad++; $display("FAIL fifo_pop%0d: got %h expected %h", i, rec_data_o[31:0], exp_pc); end
      $display("test_fifo_order: pop %0d pc=%h", i, rec_data_o[31:0]);
      step();
    end
    rec_ready_i = 1'b0;
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL fifo_empty_level: got %0d expected 0", level_o); end
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL fifo_empty_valid: got %b expected 0", rec_valid_o); end
  endtask

  task automatic test_empty_no_bypass();
    rec_ready_i = 1'b1;
    push(32'h200, 1'b0);
    n_cmp++; if (level_o !== 5'd1) begin n_bad++; $display("FAIL no_bypass: level got %0d expected 1", level_o); end
    step();
    rec_ready_i = 1'b0;
    $display("test_empty_no_bypass: level=%0d", level_o);
  endtask

  task automatic test_stop_mode();
    logic [31:0] exp_pc;
    do_clear();
    cfg_wrap_i = 1'b0;
    for (int i = 0; i < 20; i++) push(32'(4 * i), 1'b0);
    n_cmp++; if (level_o !== 5'd16) begin n_bad++; $display("FAIL stop_level: got %0d expected 16", level_o); end
    n_cmp++; if (dropped_o !== 16'd4) begin n_bad++; $display("FAIL stop_dropped: got %0d expected 4", dropped_o); end
    push(32'h1000, 1'b0);
    push(32'h1004, 1'b0);
    n_cmp++; if (dropped_o !== 16'd6) begin n_bad++; $display("FAIL stop_dropped6: got %0d expected 6", dropped_o); end
    n_cmp++; if (s_dropped_o !== 2'd3) begin n_bad++; $display("FAIL sat_dropped: got %0d expected 3", s_dropped_o); end
    rec_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_pc = 32'(4 * i);
      n_cmp++; if (rec_data_o[31:0] !== exp_pc) begin n_bad++; $display("FAIL stop_pop%0d: got %h expected %h", i, rec_data_o[31:0], exp_pc); end
      step();
    end
    rec_ready_i = 1'b0;
    $display("test_stop_mode: dropped=%0d sat_dropped=%0d level=%0d", dropped_o, s_dropped_o, level_o);
  endtask

  task automatic test_wrap_mode();
    do_clear();
    cfg_wrap_i = 1'b1;
    for (int i = 0; i < 20; i++) push(32'(4 * i), 1'b0);
    n_cmp++; if (level_o !== 5'd16) begin n_bad++; $display("FAIL wrap_level: got %0d expected 16", level_o); end
    n_cmp++; if (dropped_o !== 16'd4) begin n_bad++; $display("FAIL wrap_dropped: got %0d expected 4", dropped_o); end
    n_cmp++; if (rec_data_o[31:0] !== 32'h10) begin n_bad++; $display("FAIL wrap_head: got %h expected 10", rec_data_o[31:0]); end
    rec_ready_i = 1'b1;
    step();
    rec_ready_i = 1'b0;
    n_cmp++; if (rec_data_o[31:0] !== 32'h14) begin n_bad++; $display("FAIL wrap_next: got %h expected 14", rec_data_o[31:0]); end
    cfg_wrap_i = 1'b0;
    $display("test_wrap_mode: level=%0d dropped=%0d head=%h", level_o, dropped_o, rec_data_o[31:0]);
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 16; i++) push(32'(4 * i), 1'b0);
    rec_ready_i = 1'b1;
    push(32'h400, 1'b0);
    rec_ready_i = 1'b0;
    n_cmp++; if (level_o !== 5'd16) begin n_bad++; $display("FAIL full_pushpop_level: got %0d expected 16", level_o); end
    n_cmp++; if (dropped_o !== 16'd0) begin n_bad++; $display("FAIL full_pushpop_dropped: got %0d expected 0", dropped_o); end
    n_cmp++; if (rec_data_o[31:0] !== 32'h4) begin n_bad++; $display("FAIL full_pushpop_head: got %h expected 4", rec_data_o[31:0]); end
    $display("test_back_to_back: level=%0d dropped=%0d head=%h", level_o, dropped_o, rec_data_o[31:0]);
  endtask

  task automatic test_clear_push();
    clear_i      = 1'b1;
    rec_ready_i  = 1'b1;
    push(32'h500, 1'b0);
    clear_i      = 1'b0;
    rec_ready_i  = 1'b0;
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL clear_level: got %0d expected 0", level_o); end
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_valid: got %b expected 0", rec_valid_o); end
    step();
    $display("test_clear_push: level=%0d valid=%b", level_o, rec_valid_o);
  endtask

  task automatic test_trigger();
    cfg_trig_en_i = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      push(32'(4 * n), (n == 5));
      if (n == 8) begin
        n_cmp++; if (frozen_o !== 1'b0) begin n_bad++; $display("FAIL trig_early: frozen got %b expected 0", frozen_o); end
      end
      if (n == 9) begin
        n_cmp++; if (frozen_o !== 1'b1) begin n_bad++; $display("FAIL trig_frozen: got %b expected 1", frozen_o); end
      end
    end
    n_cmp++; if (level_o !== 5'd9) begin n_bad++; $display("FAIL trig_level: got %0d expected 9", level_o); end
    n_cmp++; if (dropped_o !== 16'd0) begin n_bad++; $display("FAIL trig_dropped: got %0d expected 0", dropped_o); end
    rec_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rec_ready_i = 1'b0;
    n_cmp++; if (rec_data_o[31:0] !== 32'h24) begin n_bad++; $display("FAIL trig_last: got %h expected 24", rec_data_o[31:0]); end
    n_cmp++; if (level_o !== 5'd1 || frozen_o !== 1'b1) begin n_bad++; $display("FAIL trig_pop_frozen: level %0d frozen %b expected 1 1", level_o, frozen_o); end
    $display("test_trigger: frozen=%b level=%0d last=%h", frozen_o, level_o, rec_data_o[31:0]);
  endtask

  task automatic test_reset_mid_post();
    do_clear();
    push(32'h600, 1'b1);
    push(32'h604, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_cmp++; if (level_o !== 5'd0 || rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_post_level: level %0d valid %b expected 0 0", level_o, rec_valid_o); end
    n_cmp++; if (frozen_o !== 1'b0 || dropped_o !== 16'd0) begin n_bad++; $display("FAIL rst_post_flags: frozen %b dropped %0d expected 0 0", frozen_o, dropped_o); end
    // First cycle after reset is IDLE, so this retirement is not captured.
    push(32'h608, 1'b0);
    n_cmp++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL rst_post_idle: level got %0d expected 0", level_o); end
    $display("test_reset_mid_post: level=%0d frozen=%b", level_o, frozen_o);
  endtask

  initial begin
    rst_i = 1'b1; rvfi_valid_i = 1'b0; rvfi_pc_rdata_i = '0; rvfi_insn_i = '0;
    rvfi_trap_i = 1'b0; rvfi_intr_i = 1'b0; rvfi_rd_addr_i = 5'd7; rvfi_rd_wdata_i = '0;
    cfg_enable_i = 1'b0; cfg_wrap_i = 1'b0; cfg_trig_en_i = 1'b0; clear_i = 1'b0;
    rec_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    test_reset();
    test_fifo_order();
    test_empty_no_bypass();
    test_stop_mode();
    test_wrap_mode();
    test_back_to_back();
    test_clear_push();
    test_trigger();
    test_reset_mid_post();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
